window_buffer_kxk_stream: RTL and testbench
===========================================

# window_buffer_kxk_stream

Parametrised KxK sliding-window generator for the CNN datapath, the successor to the fixed 3x3 frame-buffer window block. It accepts one raster-order frame over a valid/ready input stream and stores it in an internal frame memory. It then emits every KxK window, with selectable padding and stride, over a valid/ready output stream to the downstream MAC array. Kernel size, data width and frame capacity are compile-time parameters; geometry, padding and stride are run-time configuration latched per frame.

## Interface
- DATA_W, 8, pixel width in bits (opaque, passed through unchanged)
- K, 3, kernel size; odd, 3 or 5; P = (K-1)/2
- MAX_PIXELS, 256, frame memory depth
- DIM_W, 8, width of the geometry and coordinate fields
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  latches cfg_* and begins a frame; honoured only in IDLE
- cfg_width, cfg_height  in  DIM_W  frame W, H
- cfg_pad_mode  in  2  00 valid (no pad), 01 zero, 10 edge replicate, 11 reflect
- cfg_stride  in  2  1 or 2; 0 and 3 are invalid
- in_valid, in_ready  in/out  1  input handshake
- in_data  in  DATA_W  pixel
- out_valid, out_ready  out/in  1  output handshake
- win_data  out  K*K*DATA_W  element (i,j) at bits [(i*K+j)*DATA_W +: DATA_W]; i is the row offset (top = 0), j is the column offset (left = 0)
- out_row, out_col  out  DIM_W  window centre coordinates
- out_last  out  1  marks the final window of the frame
- busy  out  1  high in LOAD or EMIT
- done  out  1  one-cycle pulse after the final window handshake
- cfg_err  out  1  one-cycle pulse when a start is rejected

## Operation
- FSM states: IDLE, LOAD, EMIT.
- IDLE -> LOAD on start with a valid configuration. Config is latched here and internal logic uses only the latched values.
- Invalid configuration:
  - W = 0 or H = 0
  - W*H > MAX_PIXELS
  - stride not in {1,2}
  - mode 00 with W < K or H < K
  - mode 11 with W < P+1 or H < P+1
- On an invalid configuration: pulse cfg_err and stay in IDLE.
- LOAD:
  - in_ready = 1.
  - Each in_valid & in_ready writes pixel n at mem[n], n = r*W + c.
  - After the W*H-th pixel, go to EMIT.
- EMIT: scan centres in raster order.
  - Mode 00: r, c run from P to H-1-P (W-1-P for c) in steps of S.
  - Other modes: r, c run from 0 to H-1 (W-1 for c) in steps of S.
- Out-of-range index x in [-P, -1] or [D, D+P-1], where D = H for rows and D = W for columns:
  - Zero mode: the element is 0.
  - Edge mode: clamp x to 0 or D-1.
  - Reflect mode: x -> -x, and x -> 2(D-1)-x (mirror, edge not repeated).
- Address arithmetic uses widths sufficient for MAX_PIXELS with no wrap. Row and column are resolved separately before the multiply.
- out_last = 1 on the final centre. The final EMIT handshake leads to IDLE with done pulsed.
- Output register: it loads the next window when !out_valid or out_ready. While out_valid & !out_ready, win_data, out_row, out_col and out_last hold stable.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready = 0).

## Timing
- Reset values: in_ready 0, out_valid 0, win_data 0, out_row 0, out_col 0, out_last 0, busy 0, done 0, cfg_err 0, state IDLE. Memory is not cleared.
- start accepted at cycle t: busy = 1 and in_ready = 1 from t+1. A reject makes cfg_err = 1 at t+1 only.
- Last pixel accepted at u: in_ready = 0 at u+1 (EMIT). The first window has out_valid = 1 at u+2.
- With out_ready held 1, one window per cycle with no bubbles.
- Final handshake at v: out_valid = 0, busy = 0 and done = 1 at v+1. start is accepted again from v+1.
- rst mid-frame: on the next edge all outputs take their reset values, any partial frame is discarded, and the state is IDLE.

## Test plan
- K=3, 4x4 frame with pixel = r*4+c, zero pad, S=1, out_ready=1:
  - 16 windows.
  - (0,0) = {0,0,0, 0,0,1, 0,4,5}.
  - (3,3) = {10,11,0, 14,15,0, 0,0,0}, with out_last = 1.
  - done pulses one cycle later.
- Same frame in valid mode: 4 windows, centres (1,1), (1,2), (2,1), (2,2). (1,1) = {0,1,2, 4,5,6, 8,9,10}.
- Same frame, window (0,0):
  - Edge mode gives {0,0,1, 0,0,1, 4,4,5}.
  - Reflect mode gives {5,4,5, 1,0,1, 5,4,5}.
- 5x5 frame, zero pad, S=2: 9 windows at centres (0,0), (0,2), … (4,4), with out_last only at (4,4).
- Backpressure: random out_ready on the 4x4 frame. No window is lost or duplicated, and outputs stay stable while stalled.
- Errors:
  - start with 20x20 (MAX_PIXELS=256): cfg_err pulse, busy stays 0, in_ready stays 0.
  - rst asserted after 5 pixels loaded: all outputs at reset values next cycle; a new frame then completes correctly.

Source files
------------

// File: rtl/window_buffer_kxk_stream.sv
// KxK sliding-window generator: captures one raster-order frame into an
// internal memory, then streams every KxK window (with padding and stride)
// to the downstream MAC array over a valid/ready interface.
module window_buffer_kxk_stream #(
  parameter int DATA_W     = 8,
  parameter int K          = 3,
  parameter int MAX_PIXELS = 256,
  parameter int DIM_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIM_W-1:0]        cfg_width,
  input  logic [DIM_W-1:0]        cfg_height,
  input  logic [1:0]              cfg_pad_mode,
  input  logic [1:0]              cfg_stride,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic [DIM_W-1:0]        out_row,
  output logic [DIM_W-1:0]        out_col,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int P     = (K - 1) / 2;
  localparam int AW    = (MAX_PIXELS > 1) ? $clog2(MAX_PIXELS) : 1;
  localparam int CNT_W = AW + 1;
  localparam int PW    = 2 * DIM_W;
  localparam int CW    = DIM_W + 2;
  localparam int WW    = K * K * DATA_W;

  localparam logic [PW:0]           MAXP_C    = (PW + 1)'(MAX_PIXELS);
  localparam logic [DIM_W-1:0]      DIM_ZERO  = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]      K_C       = DIM_W'(K);
  localparam logic [DIM_W-1:0]      P_C       = DIM_W'(P);
  localparam logic [DIM_W-1:0]      P1_C      = DIM_W'(P + 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0]  C_ZERO    = {CW{1'b0}};
  localparam logic signed [CW-1:0]  C_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0]  C_P       = CW'(P);

  localparam logic [1:0] PAD_VALID = 2'b00;
  localparam logic [1:0] PAD_ZERO  = 2'b01;
  localparam logic [1:0] PAD_EDGE  = 2'b10;
  localparam logic [1:0] PAD_REFL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  // Maps a possibly out-of-range coordinate onto the frame. Returns
  // {zero_flag, index}; zero_flag means the element is forced to zero.
  function automatic logic [DIM_W:0] resolve_idx(input logic signed [CW-1:0] x,
                                                 input logic [DIM_W-1:0] d,
                                                 input logic [1:0] mode);
    logic signed [CW-1:0] ds;
    logic signed [CW-1:0] t;
    logic                 z;
    ds = signed'({2'b00, d});
    t  = C_ZERO;
    z  = 1'b0;
    if (x < C_ZERO) begin
      case (mode)
        PAD_EDGE: t = C_ZERO;
        PAD_REFL: t = C_ZERO - x;
        default:  z = 1'b1;
      endcase
    end else if (x >= ds) begin
      case (mode)
        PAD_EDGE: t = ds - C_ONE;
        PAD_REFL: t = (ds - C_ONE) + (ds - C_ONE) - x;
        default:  z = 1'b1;
      endcase
    end else begin
      t = x;
    end
    return {z, t[DIM_W-1:0]};
  endfunction

  logic [DATA_W-1:0] mem [MAX_PIXELS];

  logic [DIM_W-1:0] w_r, h_r;
  logic [1:0]       mode_r, stride_r;
  logic [CNT_W-1:0] total_r, pix_cnt_r;
  logic [DIM_W-1:0] row_r, col_r;
  logic             scan_left_r;
  logic             in_ready_r, busy_r, done_r, cfg_err_r;
  logic             out_valid_r, out_last_r;
  logic [WW-1:0]    win_r;
  logic [DIM_W-1:0] out_row_r, out_col_r;

  logic [PW-1:0]    cfg_area_s;
  logic             cfg_bad_s;
  logic             start_ok_s;
  logic             in_acc_s;
  logic             load_en_s;
  logic             last_hs_s;
  logic [DIM_W-1:0] r_start_s, r_end_s, c_start_s, c_end_s;
  logic [DIM_W:0]   row_nxt_s, col_nxt_s;
  logic             row_wrap_s, col_wrap_s, last_win_s;
  logic [WW-1:0]    win_s;

  assign cfg_area_s = PW'(cfg_width) * PW'(cfg_height);
  assign cfg_bad_s  = (cfg_width == DIM_ZERO) || (cfg_height == DIM_ZERO) ||
                      ({1'b0, cfg_area_s} > MAXP_C) ||
                      ((cfg_stride != 2'd1) && (cfg_stride != 2'd2)) ||
                      ((cfg_pad_mode == PAD_VALID) && ((cfg_width < K_C) || (cfg_height < K_C))) ||
                      ((cfg_pad_mode == PAD_REFL) && ((cfg_width < P1_C) || (cfg_height < P1_C)));

  assign start_ok_s = (state_r == S_IDLE) && start && !cfg_bad_s;
  assign in_acc_s   = (state_r == S_LOAD) && in_valid && in_ready_r;
  assign load_en_s  = (state_r == S_EMIT) && scan_left_r && (!out_valid_r || out_ready);
  assign last_hs_s  = (state_r == S_EMIT) && out_valid_r && out_ready && out_last_r;

  // Scan bounds: valid mode keeps the whole kernel inside the frame.
  always_comb begin
    if (mode_r == PAD_VALID) begin
      r_start_s = P_C;
      c_start_s = P_C;
      r_end_s   = h_r - P1_C;
      c_end_s   = w_r - P1_C;
    end else begin
      r_start_s = DIM_ZERO;
      c_start_s = DIM_ZERO;
      r_end_s   = h_r - DIM_W'(1);
      c_end_s   = w_r - DIM_W'(1);
    end
  end

  assign row_nxt_s  = {1'b0, row_r} + (DIM_W + 1)'(stride_r);
  assign col_nxt_s  = {1'b0, col_r} + (DIM_W + 1)'(stride_r);
  assign row_wrap_s = row_nxt_s > {1'b0, r_end_s};
  assign col_wrap_s = col_nxt_s > {1'b0, c_end_s};
  assign last_win_s = row_wrap_s && col_wrap_s;

  // Assemble the window around the current scan centre; rows and columns
  // are resolved independently before forming the memory address.
  always_comb begin
    logic [DIM_W:0]  rres_v;
    logic [DIM_W:0]  cres_v;
    logic [AW-1:0]   base_v;
    logic [AW-1:0]   addr_v;
    win_s  = {WW{1'b0}};
    rres_v = {(DIM_W + 1){1'b0}};
    cres_v = {(DIM_W + 1){1'b0}};
    base_v = {AW{1'b0}};
    addr_v = {AW{1'b0}};
    for (int i = 0; i < K; i++) begin
      rres_v = resolve_idx(signed'({2'b00, row_r}) + CW'(i) - C_P, h_r, mode_r);
      base_v = AW'(rres_v[DIM_W-1:0]) * AW'(w_r);
      for (int j = 0; j < K; j++) begin
        cres_v = resolve_idx(signed'({2'b00, col_r}) + CW'(j) - C_P, w_r, mode_r);
        addr_v = base_v + AW'(cres_v[DIM_W-1:0]);
        if (rres_v[DIM_W] || cres_v[DIM_W]) begin
          win_s[(i*K+j)*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        end else begin
          win_s[(i*K+j)*DATA_W +: DATA_W] = mem[addr_v];
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_acc_s && (pix_cnt_r == total_r - CNT_ONE)) begin
          state_nxt_s = S_EMIT;
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_EMIT: begin
        if (last_hs_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_EMIT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Frame memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (in_acc_s) begin
      mem[pix_cnt_r[AW-1:0]] <= in_data;
    end
  end

  // Config latch, pixel counter, scan position and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_r         <= DIM_ZERO;
      h_r         <= DIM_ZERO;
      mode_r      <= 2'b00;
      stride_r    <= 2'b01;
      total_r     <= CNT_ZERO;
      pix_cnt_r   <= CNT_ZERO;
      row_r       <= DIM_ZERO;
      col_r       <= DIM_ZERO;
      scan_left_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      win_r       <= {WW{1'b0}};
      out_row_r   <= DIM_ZERO;
      out_col_r   <= DIM_ZERO;
    end else begin
      in_ready_r <= (state_nxt_s == S_LOAD);
      busy_r     <= (state_nxt_s != S_IDLE);
      done_r     <= last_hs_s;
      cfg_err_r  <= (state_r == S_IDLE) && start && cfg_bad_s;

      if (start_ok_s) begin
        w_r       <= cfg_width;
        h_r       <= cfg_height;
        mode_r    <= cfg_pad_mode;
        stride_r  <= cfg_stride;
        total_r   <= cfg_area_s[CNT_W-1:0];
        pix_cnt_r <= CNT_ZERO;
      end else if (in_acc_s) begin
        pix_cnt_r <= pix_cnt_r + CNT_ONE;
      end

      if ((state_r == S_LOAD) && (state_nxt_s == S_EMIT)) begin
        row_r       <= r_start_s;
        col_r       <= c_start_s;
        scan_left_r <= 1'b1;
      end else if (load_en_s) begin
        scan_left_r <= !last_win_s;
        if (col_wrap_s) begin
          col_r <= c_start_s;
          row_r <= row_nxt_s[DIM_W-1:0];
        end else begin
          col_r <= col_nxt_s[DIM_W-1:0];
        end
      end

      if (load_en_s) begin
        out_valid_r <= 1'b1;
        win_r       <= win_s;
        out_row_r   <= row_r;
        out_col_r   <= col_r;
        out_last_r  <= last_win_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_err   = cfg_err_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign win_data  = win_r;
  assign out_row   = out_row_r;
  assign out_col   = out_col_r;

endmodule

// File: tb/tb_window_buffer_kxk_stream.sv
// Self-checking bench for window_buffer_kxk_stream: hand-computed vector
// table plus randomized frames checked against a behavioural window model.
module tb_window_buffer_kxk_stream;

  localparam int DATA_W = 8;
  localparam int K      = 3;
  localparam int MAXP   = 256;
  localparam int DIM_W  = 8;
  localparam int P      = (K - 1) / 2;
  localparam int WW     = K * K * DATA_W;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [DIM_W-1:0]  cfg_width, cfg_height;
  logic [1:0]        cfg_pad_mode, cfg_stride;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready;
  logic [WW-1:0]     win_data;
  logic [DIM_W-1:0]  out_row, out_col;
  logic              out_last, busy, done, cfg_err;

  window_buffer_kxk_stream #(.DATA_W(DATA_W), .K(K), .MAX_PIXELS(MAXP), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_pad_mode(cfg_pad_mode), .cfg_stride(cfg_stride),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .win_data(win_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int frame [MAXP];

  typedef struct {
    int            row;
    int            col;
    logic [WW-1:0] win;
    bit            last;
  } win_t;

  typedef struct {
    int            w, h, mode, s, cnt, cr, cc;
    logic [WW-1:0] win;
  } vec_t;

  win_t exp_q[$];
  win_t cap_q[$];

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Padding rule on one axis: -1 means "element is zero".
  function automatic int res(input int x, input int d, input int mode);
    if (x >= 0 && x < d) return x;
    if (mode == 2) return (x < 0) ? 0 : d - 1;
    if (mode == 3) return (x < 0) ? -x : 2 * (d - 1) - x;
    return -1;
  endfunction

  function automatic logic [WW-1:0] ref_win(input int w, h, mode, r, c);
    logic [WW-1:0] acc;
    int rr, cc, v;
    acc = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        rr = res(r + i - P, h, mode);
        cc = res(c + j - P, w, mode);
        v  = (rr < 0 || cc < 0) ? 0 : frame[rr * w + cc];
        acc[(i*K+j)*DATA_W +: DATA_W] = DATA_W'(v);
      end
    return acc;
  endfunction

  task automatic build_exp(input int w, h, mode, s);
    int lo_r, hi_r, lo_c, hi_c;
    win_t e;
    exp_q.delete();
    lo_r = (mode == 0) ? P : 0;  hi_r = (mode == 0) ? h - 1 - P : h - 1;
    lo_c = (mode == 0) ? P : 0;  hi_c = (mode == 0) ? w - 1 - P : w - 1;
    for (int r = lo_r; r <= hi_r; r += s)
      for (int c = lo_c; c <= hi_c; c += s) begin
        e.row = r; e.col = c; e.last = 1'b0;
        e.win = ref_win(w, h, mode, r, c);
        exp_q.push_back(e);
      end
    exp_q[exp_q.size() - 1].last = 1'b1;
  endtask

  function automatic logic [127:0] pack_out(input int r, c, input bit l, input logic [WW-1:0] wv);
    return {8'(r), 8'(c), l, wv};
  endfunction

  task automatic fill_ramp(input int w, h);
    for (int n = 0; n < w * h; n++) frame[n] = n & 255;
  endtask

  task automatic check_reset_outs(input string name);
    check_eq(name, {in_ready, out_valid, out_last, busy, done, cfg_err, out_row, out_col, win_data}, '0);
  endtask

  // Full frame: load with optional input gaps, collect windows with
  // optional backpressure, compare every window against the model.
  task automatic run_frame(input int w, h, mode, s, rdy_pct, gap_pct);
    int total, n, cyc, got;
    bit prev_stall;
    logic [127:0] cur, snap;
    win_t cw;
    total = w * h;
    build_exp(w, h, mode, s);
    cap_q.delete();
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
    cfg_pad_mode = 2'(mode); cfg_stride = 2'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy_ready", {busy, in_ready}, 2'b11);
    n = 0; cyc = 0;
    while (n < total && cyc < 4000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = DATA_W'(frame[n]);
      if (in_valid && in_ready) n++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("load_pixels", n, total);
    check_eq("load_end", {in_ready, out_valid}, 2'b00);
    out_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    check_eq("first_win_valid", out_valid, 1'b1);
    got = 0; cyc = 0; prev_stall = 1'b0; snap = '0;
    while (got < exp_q.size() && cyc < 4000) begin
      cur = pack_out(out_row, out_col, out_last, win_data);
      if (prev_stall) check_eq("stall_stable", cur, snap);
      if (rdy_pct >= 100) check_eq("no_bubble", out_valid, 1'b1);
      out_ready = ($urandom_range(99) < rdy_pct);
      if (out_valid && out_ready) begin
        check_eq("window", cur, pack_out(exp_q[got].row, exp_q[got].col, exp_q[got].last, exp_q[got].win));
        cw.row = out_row; cw.col = out_col; cw.last = out_last; cw.win = win_data;
        cap_q.push_back(cw);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      snap = cur;
      @(negedge clk);
      cyc++;
    end
    check_eq("emit_count", got, exp_q.size());
    check_eq("end_state", {out_valid, busy, done}, 3'b001);
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", done, 1'b0);
  endtask

  vec_t tbl [7];
  int   bad [6][4];

  initial begin
    int w, h, mode, s;
    bit found;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h, mode, s;
    bit found;
    logic [WW-1:0] fw;

    tbl[0] = '{4, 4, 1, 1, 16, 0, 0, pk(0,0,0, 0,0,1, 0,4,5)};
    tbl[1] = '{4, 4, 1, 1, 16, 3, 3, pk(10,11,0, 14,15,0, 0,0,0)};
    tbl[2] = '{4, 4, 0, 1,  4, 1, 1, pk(0,1,2, 4,5,6, 8,9,10)};
    tbl[3] = '{4, 4, 0, 1,  4, 2, 2, pk(5,6,7, 9,10,11, 13,14,15)};
    tbl[4] = '{4, 4, 2, 1, 16, 0, 0, pk(0,0,1, 0,0,1, 4,4,5)};
    tbl[5] = '{4, 4, 3, 1, 16, 0, 0, pk(5,4,5, 1,0,1, 5,4,5)};
    tbl[6] = '{5, 5, 1, 2,  9, 4, 4, pk(18,19,0, 23,24,0, 0,0,0)};

    bad[0] = '{20, 20, 1, 1};
    bad[1] = '{ 0,  4, 1, 1};
    bad[2] = '{ 4,  4, 1, 0};
    bad[3] = '{ 4,  4, 1, 3};
    bad[4] = '{ 2,  4, 0, 1};
    bad[5] = '{ 4,  1, 3, 1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_pad_mode = '0; cfg_stride = '0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Hand-computed windows from the ramp frame.
    for (int t = 0; t < 7; t++) begin
      fill_ramp(tbl[t].w, tbl[t].h);
      run_frame(tbl[t].w, tbl[t].h, tbl[t].mode, tbl[t].s, 100, 0);
      check_eq("tbl_count", cap_q.size(), tbl[t].cnt);
      found = 1'b0; fw = '0;
      foreach (cap_q[k])
        if (cap_q[k].row == tbl[t].cr && cap_q[k].col == tbl[t].cc) begin
          found = 1'b1; fw = cap_q[k].win;
        end
      check_eq("tbl_found", found, 1'b1);
      check_eq("tbl_win", fw, tbl[t].win);
    end

    // Rejected configurations.
    for (int t = 0; t < 6; t++) begin
      cfg_width = DIM_W'(bad[t][0]); cfg_height = DIM_W'(bad[t][1]);
      cfg_pad_mode = 2'(bad[t][2]); cfg_stride = 2'(bad[t][3]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("cfg_err_pulse", {cfg_err, busy, in_ready}, 3'b100);
      @(negedge clk);
      check_eq("cfg_err_clear", {cfg_err, busy, in_ready}, 3'b000);
    end

    // Reset in the middle of a load, then a clean frame.
    fill_ramp(4, 4);
    cfg_width = 8'd4; cfg_height = 8'd4; cfg_pad_mode = 2'd1; cfg_stride = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1; in_data = 8'(n + 100);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("mid_frame_reset");
    rst = 1'b0;
    @(negedge clk);
    run_frame(4, 4, 1, 1, 100, 0);

    // Backpressure on the 4x4 frame.
    run_frame(4, 4, 1, 1, 40, 0);
    run_frame(4, 4, 3, 1, 50, 20);

    // Randomized geometry, mode, stride and pixel data.
    for (int t = 0; t < 8; t++) begin
      w = $urandom_range(16, 1); h = $urandom_range(16, 1);
      mode = $urandom_range(3); s = $urandom_range(2, 1);
      if (mode == 0 && (w < K || h < K)) mode = 1;
      if (mode == 3 && (w < P + 1 || h < P + 1)) mode = 2;
      for (int n = 0; n < w * h; n++) frame[n] = $urandom_range(255);
      run_frame(w, h, mode, s, 60, 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
